// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher.
// A start request loads the ciphertext and cipher key. The block then spends 10 cycles
// expanding the key forward to round key 10. It spends 11 more cycles on the inverse
// rounds, stepping the key schedule backwards one round per cycle, so no round-key
// storage is needed.
// Internal layout: FIPS byte k of a block sits at bits [8k+7:8k]. Byte 4c+r is row r,
// column c. Ports carry FIPS byte 0 in bits [127:120], so data is byte-flipped on the
// way in and on the way out.
module aes_inv_cipher #(
  parameter int NB   = 128,
  parameter int NR   = 10,
  parameter int BYTE = 8,
  parameter int WORD = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [NB-1:0] cipher_text,
  input  logic [NB-1:0] key,
  output logic          done,
  output logic [NB-1:0] plain_text
);

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT} state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (the result is 0 for 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(x240, x14);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  // Forward S-box: inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------
  // Block-level transforms
  // ---------------------------------------------------------------------------
  function automatic logic [NB-1:0] byte_flip(input logic [NB-1:0] x);
    logic [NB-1:0] y;
    for (int k = 0; k < NB / BYTE; k++) y[BYTE*k +: BYTE] = x[NB-BYTE*(k+1) +: BYTE];
    return y;
  endfunction

  function automatic logic [NB-1:0] inv_sub_bytes(input logic [NB-1:0] s);
    logic [NB-1:0] y;
    for (int k = 0; k < NB / BYTE; k++) y[BYTE*k +: BYTE] = inv_sbox(s[BYTE*k +: BYTE]);
    return y;
  endfunction

  // Row r is rotated right by r columns: output column c takes input column c-r
  function automatic logic [NB-1:0] inv_shift_rows(input logic [NB-1:0] s);
    logic [NB-1:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[BYTE*(4*c+r) +: BYTE] = s[BYTE*(4*((c-r+4)%4)+r) +: BYTE];
    return y;
  endfunction

  function automatic logic [NB-1:0] inv_mix_columns(input logic [NB-1:0] s);
    logic [NB-1:0] y;
    logic [7:0]    a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BYTE*(4*c+0) +: BYTE];
      a1 = s[BYTE*(4*c+1) +: BYTE];
      a2 = s[BYTE*(4*c+2) +: BYTE];
      a3 = s[BYTE*(4*c+3) +: BYTE];
      y[BYTE*(4*c+0) +: BYTE] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      y[BYTE*(4*c+1) +: BYTE] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      y[BYTE*(4*c+2) +: BYTE] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      y[BYTE*(4*c+3) +: BYTE] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return y;
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule (word j = bits [32j+31:32j], its first FIPS byte in the low byte)
  // ---------------------------------------------------------------------------
  function automatic logic [WORD-1:0] rot_word(input logic [WORD-1:0] w);
    return {w[BYTE-1:0], w[WORD-1:BYTE]};
  endfunction

  function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
    logic [WORD-1:0] y;
    for (int i = 0; i < WORD / BYTE; i++) y[BYTE*i +: BYTE] = sbox(w[BYTE*i +: BYTE]);
    return y;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round key i -> round key i+1
  function automatic logic [NB-1:0] fwd_key_step(input logic [NB-1:0] rk, input logic [7:0] rc);
    logic [WORD-1:0] w0, w1, w2, w3, n0, n1, n2, n3;
    w0 = rk[0*WORD +: WORD];
    w1 = rk[1*WORD +: WORD];
    w2 = rk[2*WORD +: WORD];
    w3 = rk[3*WORD +: WORD];
    n0 = w0 ^ sub_word(rot_word(w3)) ^ {24'h0, rc};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  // Round key i -> round key i-1, using the Rcon that produced round key i
  function automatic logic [NB-1:0] inv_key_step(input logic [NB-1:0] rk, input logic [7:0] rc);
    logic [WORD-1:0] n0, n1, n2, n3, w0, w1, w2, w3;
    n0 = rk[0*WORD +: WORD];
    n1 = rk[1*WORD +: WORD];
    n2 = rk[2*WORD +: WORD];
    n3 = rk[3*WORD +: WORD];
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_word(rot_word(w3)) ^ {24'h0, rc};
    return {w3, w2, w1, w0};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and datapath
  // ---------------------------------------------------------------------------
  state_e        fsm_q;
  logic [3:0]    rnd_q;
  logic [NB-1:0] state_q;
  logic [NB-1:0] rk_q;
  logic [NB-1:0] plain_q;
  logic          done_q;

  logic [7:0]    rcon_sel;
  logic [NB-1:0] rk_fwd;
  logic [NB-1:0] rk_inv;
  logic [NB-1:0] inv_core;
  logic [NB-1:0] round_out;

  // Select the round constant: Rcon(rnd+1) while expanding, Rcon(10-rnd) while decrypting
  always_comb begin
    // NOTE: default first so every path assigns rcon_sel and no latch is inferred
    rcon_sel = 8'h00;
    case (fsm_q)
      EXPAND:  rcon_sel = rcon(rnd_q + 4'd1);
      DECRYPT: rcon_sel = rcon(4'(NR) - rnd_q);
      default: ;
    endcase
  end

  assign rk_fwd    = fwd_key_step(rk_q, rcon_sel);
  assign rk_inv    = inv_key_step(rk_q, rcon_sel);
  assign inv_core  = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_q;
  assign round_out = inv_mix_columns(inv_core);

  // Control FSM, round counter and all datapath registers
  // NOTE: non-blocking assignments so every register samples pre-edge values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the datapath registers are reset too, so an aborted run leaves nothing behind
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      rk_q    <= '0;
      plain_q <= '0;
      done_q  <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= byte_flip(cipher_text);
            rk_q    <= byte_flip(key);
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
            fsm_q   <= EXPAND;
          end
        end
        EXPAND: begin
          rk_q <= rk_fwd;
          if (rnd_q == 4'(NR - 1)) begin
            rnd_q <= 4'd0;
            fsm_q <= DECRYPT;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DECRYPT: begin
          if (rnd_q == 4'd0) begin
            state_q <= state_q ^ rk_q;
            rk_q    <= rk_inv;
            rnd_q   <= rnd_q + 4'd1;
          end else if (rnd_q == 4'(NR)) begin
            plain_q <= byte_flip(inv_core);
            done_q  <= 1'b1;
            rnd_q   <= 4'd0;
            fsm_q   <= IDLE;
          end else begin
            state_q <= round_out;
            rk_q    <= rk_inv;
            rnd_q   <= rnd_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign plain_text = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher.
// The driver issues runs and queues the expected plaintext. The monitor pops the queue and
// compares on every completion. It also checks the 21-cycle latency and that plain_text
// holds while the block is busy. The random round trip uses a textbook AES-128 encryption
// model. Its S-box is built by brute-force field inversion.
module tb_aes_inv_cipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic         done;
  logic [127:0] plain_text;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cycle = 0;
  int           busy  = 0;
  logic [127:0] last_pt;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];

  aes_inv_cipher dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .cipher_text (cipher_text),
    .key         (key),
    .done        (done),
    .plain_text  (plain_text)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // Blocks in FIPS order: byte k at [127-8k -: 8], byte r+4c is row r, column c
  function automatic logic [127:0] m_sub(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox_t[v[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] v);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-8*(4*c+0) -: 8];
      a1 = v[127-8*(4*c+1) -: 8];
      a2 = v[127-8*(4*c+2) -: 8];
      a3 = v[127-8*(4*c+3) -: 8];
      o[127-8*(4*c+0) -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      s = m_shift(m_sub(s));
      if (r != 10) s = m_mix(s);
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  function automatic logic [127:0] bflip(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = x[127-8*k -: 8];
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    last_pt = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        busy    = 0;
        last_pt = '0;
      end else if (!done) begin
        busy++;
        check("hold_while_busy", plain_text, last_pt);
      end else if (busy > 0) begin
        check("latency", 128'(busy), 128'(21));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h, expected no completion", plain_text);
        end else begin
          last_pt = exp_q.pop_front();
          check("result", plain_text, last_pt);
        end
        busy = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] e);
    cipher_text = ct;
    key         = k;
    start       = 1'b1;
    exp_q.push_back(e);
  endtask

  // mode 0: start low while busy; 1: random start pulses and inputs; 2: start held, inputs random
  task automatic wait_idle(input int mode);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
      case (mode)
        0: start = 1'b0;
        1: begin
          start       = 1'($urandom_range(0, 1));
          cipher_text = rand128();
          key         = rand128();
        end
        default: begin
          start       = 1'b1;
          cipher_text = rand128();
          key         = rand128();
        end
      endcase
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: done=%b after 100 cycles, expected 1", done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_prev;
    int t_now;
    logic [127:0] pt, k;
    build_sbox();
    rstn        = 1'b1;
    start       = 1'b0;
    cipher_text = '0;
    key         = '0;
    #1 rstn = 1'b0;
    #3;
    check("reset_done", 128'(done), 128'(1));
    check("reset_plain", plain_text, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // FIPS-197 C.1
    @(negedge clk);
    issue(C1_CT, C1_KEY, C1_PT);
    wait_idle(0);

    // FIPS-197 App. B, plus round key 10 after the expansion phase
    issue(B_CT, B_KEY, B_PT);
    repeat (11) @(posedge clk);
    #1 check("rk10_after_expand", bflip(dut.rk_q), B_RK10);
    wait_idle(0);

    // start held high, alternating vectors, inputs scrambled mid-run
    t_prev = 0;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) issue(C1_CT, C1_KEY, C1_PT);
      else            issue(B_CT, B_KEY, B_PT);
      wait_idle(2);
      t_now = cycle;
      if (j > 0) check("b2b_period", 128'(t_now - t_prev), 128'(22));
      t_prev = t_now;
    end
    start = 1'b0;

    // reset at edge 12 of a run, then a fresh run
    @(negedge clk);
    issue(C1_CT, C1_KEY, C1_PT);
    repeat (13) @(posedge clk);
    #2 rstn = 1'b0;
    start = 1'b0;
    exp_q.delete();
    #1;
    check("midrun_reset_done", 128'(done), 128'(1));
    check("midrun_reset_plain", plain_text, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(C1_CT, C1_KEY, C1_PT);
    wait_idle(0);

    // random round trip with start pulses and input changes while busy
    for (int i = 0; i < 200; i++) begin
      pt = rand128();
      k  = rand128();
      issue(m_encrypt(pt, k), k, pt);
      wait_idle(1);
    end
    start = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
